// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: FSM state encoding,
// bus bit values and byte width.
package i2c_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 4;

    localparam logic BIT_ACK  = 1'b0;
    localparam logic BIT_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_MACK      = 4'd8,
        ST_WAIT      = 4'd9
    } state_e;

    function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] v, input logic b);
        return {v[BYTE_W-2:0], b};
    endfunction

endpackage

// File: rtl/i2c_slave_regs_if.sv
// Register-side bus of the I2C target: pointer, write data/strobe,
// read strobe/data and the transaction-busy flag.
interface i2c_slave_regs_if;

    logic [7:0] REG_ADDR;
    logic [7:0] REG_WDATA;
    logic       REG_WE;
    logic       REG_RD;
    logic [7:0] REG_RDATA;
    logic       BUSY;

    modport master (
        output REG_ADDR, REG_WDATA, REG_WE, REG_RD, BUSY,
        input  REG_RDATA
    );

    modport slave (
        input  REG_ADDR, REG_WDATA, REG_WE, REG_RD, BUSY,
        output REG_RDATA
    );

endinterface

// File: rtl/i2c_line_sync.sv
// 2-FF synchroniser for one I2C line with rise/fall strobes. With
// I2C_SLAVE_FILTER_EN defined, a FILTER_LEN-cycle hold filter rejects spikes.
module i2c_line_sync #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       lvl;

    if (FILTER_LEN < 1) begin : g_len_chk
        $error("FILTER_LEN must be at least 1");
    end

    always_comb sync_d = {sync_q[0], line_i};

`ifdef I2C_SLAVE_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The filtered level only follows the synced line after it has
    // disagreed for FILTER_LEN consecutive cycles.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1))
                filt_d = sync_q[1];
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[1];
`endif

    always_comb prev_d = lvl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign lvl_o  = lvl;
    assign rise_o = lvl & ~prev_q;
    assign fall_o = ~lvl & prev_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target at SLAVE_ADDR fronting an 8-bit register space: subaddress
// write, burst write and burst read. Spike filter via I2C_SLAVE_FILTER_EN.
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic             CLK,
    input  logic             RESET_N,
    inout  wire              I2C_SCL,
    inout  wire              I2C_SDA,
    i2c_slave_regs_if.master rbus
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;
    logic start_det, stop_det, byte_done;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              rw_q, rw_d;
    logic              mack_q, mack_d;
    logic [1:0]        ld_q, ld_d;
    logic              sda_oe_q, sda_oe_d;
    logic [7:0]        reg_addr_q, reg_addr_d;
    logic [7:0]        reg_wdata_q, reg_wdata_d;
    logic              reg_we_q, reg_we_d;
    logic              reg_rd_q, reg_rd_d;
    logic              busy_q, busy_d;

    i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_scl_sync (
        .clk(CLK), .rst_n(RESET_N), .line_i(I2C_SCL),
        .lvl_o(scl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sda_sync (
        .clk(CLK), .rst_n(RESET_N), .line_i(I2C_SDA),
        .lvl_o(sda), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    assign start_det = sda_fall & scl;
    assign stop_det  = sda_rise & scl;
    assign byte_done = (cnt_q == CNT_W'(BYTE_W));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        mack_d      = mack_q;
        ld_d        = {ld_q[0], 1'b0};
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_rd_d    = 1'b0;
        busy_d      = busy_q;

        if (start_det) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            ld_d     = '0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            ld_d     = '0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_in(shift_q, sda);
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && byte_done) begin
                        cnt_d = '0;
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                            sda_oe_d = 1'b1;
                            state_d  = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                // The first fall seen here ends the 9th (ACK) clock.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                        if (rw_q == RW_READ) begin
                            reg_rd_d = 1'b1;
                            ld_d     = {ld_q[0], 1'b1};
                            state_d  = ST_RDATA;
                        end else begin
                            state_d = ST_SUB;
                        end
                    end
                end
                ST_SUB: begin
                    if (scl_rise) begin
                        shift_d = shift_in(shift_q, sda);
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && byte_done) begin
                        cnt_d      = '0;
                        reg_addr_d = shift_q;
                        sda_oe_d   = 1'b1;
                        state_d    = ST_SUB_ACK;
                    end
                end
                ST_SUB_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d = shift_in(shift_q, sda);
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && byte_done) begin
                        cnt_d       = '0;
                        reg_wdata_d = shift_q;
                        reg_we_d    = 1'b1;
                        sda_oe_d    = 1'b1;
                        state_d     = ST_WDATA_ACK;
                    end
                end
                ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d   = 1'b0;
                        reg_addr_d = reg_addr_q + 8'd1;
                        state_d    = ST_WDATA;
                    end
                end
                // Read data is loaded two CLKs after REG_RD so a registered
                // register file has a full cycle to respond.
                ST_RDATA: begin
                    if (ld_q[1]) begin
                        shift_d  = rbus.REG_RDATA;
                        sda_oe_d = ~rbus.REG_RDATA[7];
                        cnt_d    = '0;
                    end else if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            cnt_d    = '0;
                            sda_oe_d = 1'b0;
                            state_d  = ST_MACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                ST_MACK: begin
                    if (scl_rise) begin
                        mack_d = sda;
                    end else if (scl_fall) begin
                        if (mack_q == BIT_ACK) begin
                            reg_addr_d = reg_addr_q + 8'd1;
                            reg_rd_d   = 1'b1;
                            ld_d       = {ld_q[0], 1'b1};
                            state_d    = ST_RDATA;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rw_q        <= RW_WRITE;
            mack_q      <= BIT_NACK;
            ld_q        <= '0;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
            ld_q        <= ld_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_rd_q    <= reg_rd_d;
            busy_q      <= busy_d;
        end
    end

    // Gating with RESET_N frees the bus in the same cycle reset is asserted.
    assign I2C_SDA = (sda_oe_q && RESET_N) ? 1'b0 : 1'bz;

    assign rbus.REG_ADDR  = reg_addr_q;
    assign rbus.REG_WDATA = reg_wdata_q;
    assign rbus.REG_WE    = reg_we_q;
    assign rbus.REG_RD    = reg_rd_q;
    assign rbus.BUSY      = busy_q;

endmodule
